// File: rtl/alu_seq_pkg.sv
// Shared opcode encoding, legality check and sequencer state type for the ALU issue stage.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;

  typedef enum logic [2:0] {
    P_OFF  = 3'd0,
    P_WAKE = 3'd1,
    IDLE   = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5,
    P_ISO  = 3'd6
  } seq_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command FIFO with show-ahead head data and a registered not-full ready.
module alu_cmd_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             ready_q;
  logic             do_push, do_pop;

  assign do_push = push && ready_q;
  assign do_pop  = pop && !empty;
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign ready   = ready_q;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)
      count_d = count_q + 1'b1;
    else if (!do_push && do_pop)
      count_d = count_q - 1'b1;
  end

  // Ready is derived from the next count so it stays a pure register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the multi-cycle ALU: buffers tagged commands, issues one at a time,
// returns tagged responses and sequences ALU power-gating around activity.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CMD_DEPTH    = 4,
  parameter int TAG_W        = 4,
  parameter int WAKE_CYCLES  = 3,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_opcode,
  output logic             alu_start,
  input  logic [15:0]      alu_result,
  input  logic             alu_busy,
  output logic             alu_pwr_en,
  output logic             iso_en,
  output logic             seq_idle
);

  localparam int CW     = 36 + TAG_W;
  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [15:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic [3:0]        op_code_q, op_code_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic              rsp_err_q, rsp_err_d;

  logic [CW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_ready, fifo_pop, take_head;

  alu_cmd_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && !fifo_full),
    .wdata ({cmd_opcode, cmd_a, cmd_b, cmd_tag}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ready (fifo_ready)
  );

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_code_d  = op_code_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    take_head  = 1'b0;

    case (state_q)
      P_OFF: if (!fifo_empty) begin
        state_d    = P_WAKE;
        wake_cnt_d = '0;
      end
      P_WAKE: if (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1)) state_d = IDLE;
              else wake_cnt_d = wake_cnt_q + 1'b1;
      IDLE: if (!fifo_empty) take_head = 1'b1;
            else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) state_d = P_ISO;
            else idle_cnt_d = idle_cnt_q + 1'b1;
      ISSUE: state_d = WAIT;
      WAIT: if (!alu_busy) begin
        rsp_data_d = alu_result;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end
      RESP: if (rsp_ready) begin
        if (!fifo_empty) take_head = 1'b1;
        else state_d = IDLE;
      end
      P_ISO: state_d = P_OFF;
      default: state_d = P_OFF;
    endcase

    // Illegal opcodes bypass the ALU and answer immediately with an error.
    if (take_head) begin
      op_code_d = fifo_rdata[CW-1 -: 4];
      op_a_d    = fifo_rdata[TAG_W+31 -: 16];
      op_b_d    = fifo_rdata[TAG_W+15 -: 16];
      rsp_tag_d = fifo_rdata[TAG_W-1:0];
      if (is_legal_op(fifo_rdata[CW-1 -: 4])) begin
        state_d = ISSUE;
      end else begin
        state_d    = RESP;
        rsp_err_d  = 1'b1;
        rsp_data_d = '0;
      end
    end

    if (state_d != IDLE) idle_cnt_d = '0;
  end

  assign fifo_pop = take_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= P_OFF;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_code_q  <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_code_q  <= op_code_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign cmd_ready  = fifo_ready;
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_opcode = op_code_q;
  assign alu_start  = (state_q == ISSUE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign alu_pwr_en = (state_q != P_OFF);
  assign iso_en     = (state_q == P_OFF) || (state_q == P_WAKE) || (state_q == P_ISO);
  assign seq_idle   = fifo_empty && ((state_q == IDLE) || (state_q == P_OFF));

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, vector table, response scoreboard and power/reset sequences.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [15:0]      cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [15:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      alu_a, alu_b, alu_result;
  logic [3:0]       alu_opcode;
  logic             alu_start, alu_busy, alu_pwr_en, iso_en, seq_idle;

  alu_cmd_sequencer #(
    .CMD_DEPTH(4), .TAG_W(TAG_W), .WAKE_CYCLES(3), .IDLE_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_busy(alu_busy),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .seq_idle(seq_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       op;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
    logic [15:0]      exp_data;
    logic             exp_err;
  } vec_t;

  typedef struct {
    logic [15:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  vec_t tbl [12];
  rsp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  logic prev_start = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Behavioural ALU: single-cycle ops answer at the start edge, MUL/DIV sample operands at completion.
  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[3:0];
      OP_SHR:  return a >> b[3:0];
      OP_XNOR: return ~(a ^ b);
      OP_MUL:  begin p = a * b; return p[15:0]; end
      OP_DIV:  return (b == 16'd0) ? 16'd0 : a / b;
      default: return 16'd0;
    endcase
  endfunction

  int          busy_cnt;
  logic [15:0] lat_a, lat_b;
  logic [3:0]  lat_op;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_busy   <= 1'b0;
      alu_result <= 16'd0;
      busy_cnt   <= 0;
      lat_a      <= 16'd0;
      lat_b      <= 16'd0;
      lat_op     <= 4'd0;
    end else if (alu_start) begin
      lat_a  <= alu_a;
      lat_b  <= alu_b;
      lat_op <= alu_opcode;
      if (alu_opcode == OP_MUL) begin
        alu_busy <= 1'b1; busy_cnt <= 5;
      end else if (alu_opcode == OP_DIV) begin
        alu_busy <= 1'b1; busy_cnt <= 9;
      end else begin
        alu_result <= alu_f(alu_opcode, alu_a, alu_b);
      end
    end else if (alu_busy) begin
      if (busy_cnt == 1) begin
        alu_busy   <= 1'b0;
        alu_result <= alu_f(alu_opcode, alu_a, alu_b);
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  // Response scoreboard: compare on the cycle the handshake will occur.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got tag %0d data 0x%0h expected no response", rsp_tag, rsp_data);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_tag", rsp_tag, e.tag);
        chk("rsp_err", rsp_err, e.err);
        $display("rsp tag=%0d data=0x%04h err=%0d", rsp_tag, rsp_data, rsp_err);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && alu_start) begin
      start_cnt++;
      chk("start_powered", {alu_pwr_en, iso_en}, 2'b10);
      chk("start_single_cycle", prev_start, 1'b0);
    end
    if (!rst && alu_busy)
      chk("operands_held", {alu_opcode, alu_a, alu_b}, {lat_op, lat_a, lat_b});
    prev_start = alu_start;
  end

  task automatic check_reset_vals(input string tagname);
    chk({tagname, "_ctrl"}, {alu_pwr_en, iso_en, alu_start, rsp_valid, seq_idle, cmd_ready}, 6'b010011);
    chk({tagname, "_alu_ops"}, {alu_opcode, alu_a, alu_b}, 36'd0);
    chk({tagname, "_rsp"}, {rsp_data, rsp_tag, rsp_err}, 21'd0);
  endtask

  task automatic send(input vec_t v, input bit track);
    int n = 0;
    rsp_t r;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = v.op; cmd_a = v.a; cmd_b = v.b; cmd_tag = v.tag;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      timeout_fail("cmd_accept");
    end else begin
      $display("cmd tag=%0d op=%0d a=0x%04h b=0x%04h", v.tag, v.op, v.a, v.b);
      if (track) begin
        r.data = v.exp_data; r.tag = v.tag; r.err = v.exp_err;
        sb.push_back(r);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout_fail("drain");
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   s0;
    logic [15:0]      hd;
    logic [TAG_W-1:0] ht;
    logic             he;

    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0;
    cmd_tag = '0; rsp_ready = 1'b1;

    tbl[0]  = '{OP_ADD,  16'd3,      16'd4,      4'd1,  16'd7,      1'b0};
    tbl[1]  = '{OP_MUL,  16'd300,    16'd200,    4'd2,  16'hEA60,   1'b0};
    tbl[2]  = '{OP_DIV,  16'd100,    16'd7,      4'd3,  16'd14,     1'b0};
    tbl[3]  = '{OP_DIV,  16'd100,    16'd0,      4'd4,  16'd0,      1'b0};
    tbl[4]  = '{4'b1100, 16'd9,      16'd9,      4'd5,  16'd0,      1'b1};
    tbl[5]  = '{OP_SUB,  16'd10,     16'd3,      4'd6,  16'd7,      1'b0};
    tbl[6]  = '{OP_XOR,  16'hF0F0,   16'h0FF0,   4'd7,  16'hFF00,   1'b0};
    tbl[7]  = '{OP_XNOR, 16'h00FF,   16'h0F0F,   4'd8,  16'hF00F,   1'b0};
    tbl[8]  = '{OP_SHL,  16'd1,      16'd4,      4'd9,  16'd16,     1'b0};
    tbl[9]  = '{OP_AND,  16'hFFFF,   16'h1234,   4'd10, 16'h1234,   1'b0};
    tbl[10] = '{4'b1010, 16'd1,      16'd2,      4'd11, 16'd0,      1'b1};
    tbl[11] = '{OP_OR,   16'h0F00,   16'h00F0,   4'd12, 16'h0FF0,   1'b0};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // One command at a time; the first one also exercises wake-up timing.
    for (int i = 0; i < 6; i++) begin
      s0 = start_cnt;
      send(tbl[i], 1'b1);
      if (i == 0) begin
        n = 0;
        while (!alu_pwr_en && n < 20) begin @(negedge clk); n++; end
        chk("wake_pwr_rise", alu_pwr_en, 1'b1);
        chk("wake_iso_held", iso_en, 1'b1);
        n = 0;
        while (iso_en && n < 20) begin @(negedge clk); n++; end
        chk("wake_cycles", n, 3);
      end
      wait_drain();
      chk($sformatf("start_count_%0d", i), start_cnt - s0, tbl[i].exp_err ? 0 : 1);
    end

    // Backpressure: one in flight plus a full FIFO, response held stable.
    rsp_ready = 1'b0;
    for (int i = 6; i < 11; i++) send(tbl[i], 1'b1);
    repeat (3) @(negedge clk);
    chk("full_cmd_ready", cmd_ready, 1'b0);
    chk("full_rsp_valid", rsp_valid, 1'b1);
    chk("bp_head_tag", rsp_tag, tbl[6].tag);
    hd = rsp_data; ht = rsp_tag; he = rsp_err;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("bp_rsp_hold", {rsp_valid, rsp_data, rsp_tag, rsp_err}, {1'b1, hd, ht, he});
    end
    rsp_ready = 1'b1;
    wait_drain();

    // Idle timeout power-down, with a command landing during the isolation cycle.
    send(tbl[11], 1'b1);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    if (!rsp_valid) timeout_fail("last_rsp");
    @(negedge clk);
    chk("idle_entry", {iso_en, seq_idle}, 2'b01);
    n = 0;
    while (!iso_en && n < 40) begin @(negedge clk); n++; end
    chk("idle_timeout_cycles", n, 16);
    chk("p_iso_pwr_on", alu_pwr_en, 1'b1);
    chk("p_iso_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_opcode = OP_MUL; cmd_a = 16'd1000; cmd_b = 16'd50; cmd_tag = 4'd15;
    $display("cmd tag=15 op=8 a=0x03e8 b=0x0032 (during P_ISO, to be aborted)");
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("p_iso_to_off", {alu_pwr_en, iso_en}, 2'b01);
    @(negedge clk);
    chk("p_off_rewake", alu_pwr_en, 1'b1);

    // Reset in the middle of a MUL wait: no response, everything back to power-off.
    n = 0;
    while (!alu_busy && n < 40) begin @(negedge clk); n++; end
    chk("mul_busy_seen", alu_busy, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_vals("midop_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_reset_quiet", {alu_pwr_en, rsp_valid, seq_idle, cmd_ready}, 4'b0011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
